// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared 7-segment glyph table and inverse decode helper for the
//               display scan path.
// Revision    : 1.0  initial release
// ============================================================================
package disp_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [7:0] DIGIT_IDLE = 8'hFF;

    typedef struct packed {
        logic       hit;
        logic [3:0] nibble;
    } seg_dec_t;

    // Active-high pattern, bit6 = segment a ... bit0 = segment g.
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h7E;
            4'h1: pat = 7'h30;
            4'h2: pat = 7'h6D;
            4'h3: pat = 7'h79;
            4'h4: pat = 7'h33;
            4'h5: pat = 7'h5B;
            4'h6: pat = 7'h5F;
            4'h7: pat = 7'h70;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h7B;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h1F;
            4'hC: pat = 7'h4E;
            4'hD: pat = 7'h3D;
            4'hE: pat = 7'h4F;
            default: pat = 7'h47;
        endcase
        return pat;
    endfunction

    function automatic seg_dec_t seg2hex(input logic [6:0] pat);
        seg_dec_t res;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            if (hex2seg(4'(i)) == pat) begin
                res.hit    = 1'b1;
                res.nibble = 4'(i);
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg2hex_lut.sv
`default_nettype none
// ============================================================================
// Module      : seg2hex_lut
// Description : Combinational inverse glyph lookup, pattern -> {hit,nibble}.
// Revision    : 1.0  initial release
// ============================================================================
module seg2hex_lut
    import disp_pkg::*;
(
    input  logic [6:0] pattern,
    output seg_dec_t   result
);

    assign result = seg2hex(pattern);

endmodule
`default_nettype wire

// File: rtl/display_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_decoder
// Description : Rebuilds value and point markers from a multiplexed,
//               active-low 7-segment scan bus; flags bad glyphs and lost scan.
// Revision    : 1.0  initial release
// ============================================================================
module display_scan_decoder
    import disp_pkg::*;
#(
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 16384
) (
    input  logic        clk5,
    input  logic        reset,
    input  logic [7:0]  digit,
    input  logic [7:0]  segment,
    output logic [15:0] dispValOut,
    output logic [3:0]  pointOut,
    output logic        frameValid,
    output logic        frameChanged,
    output logic        decodeErr,
    output logic        scanLost
);

    localparam int c_SET_W = $clog2(SETTLE + 1);
    localparam int c_TO_W  = $clog2(TIMEOUT + 1);

    logic [7:0]            r_digit;
    logic [c_SET_W-1:0]    r_settle_cnt;
    logic [c_TO_W-1:0]     r_timeout_cnt;
    logic [15:0]           r_shadow_val;
    logic [NUM_DIGITS-1:0] r_shadow_pt;
    logic [NUM_DIGITS-1:0] r_seen;
    logic [15:0]           r_disp_val;
    logic [NUM_DIGITS-1:0] r_point;
    logic                  r_frame_valid;
    logic                  r_frame_changed;
    logic                  r_decode_err;

    logic                  w_digit_valid;
    logic [1:0]            w_index;
    logic                  w_stable;
    logic                  w_sample;
    logic                  w_accept;
    seg_dec_t              w_dec;

    seg2hex_lut u_lut (
        .pattern (~segment[7:1]),
        .result  (w_dec)
    );

    // Exactly one low enable among the four used bits qualifies a digit.
    always_comb begin
        w_digit_valid = 1'b0;
        w_index       = 2'd0;
        if (digit[7:4] == DIGIT_IDLE[7:4]) begin
            case (digit[3:0])
                4'b1110: begin w_digit_valid = 1'b1; w_index = 2'd0; end
                4'b1101: begin w_digit_valid = 1'b1; w_index = 2'd1; end
                4'b1011: begin w_digit_valid = 1'b1; w_index = 2'd2; end
                4'b0111: begin w_digit_valid = 1'b1; w_index = 2'd3; end
                default: begin w_digit_valid = 1'b0; w_index = 2'd0; end
            endcase
        end
    end

    assign w_stable = (digit == r_digit);
    // Fires on the single edge where the settle count climbs to SETTLE.
    assign w_sample = w_stable && w_digit_valid &&
                      (r_settle_cnt == c_SET_W'(SETTLE - 1));
    assign w_accept = w_sample && w_dec.hit;

    always_ff @(posedge clk5) begin
        if (reset) begin
            r_digit         <= '0;
            r_settle_cnt    <= '0;
            r_timeout_cnt   <= '0;
            r_shadow_val    <= '0;
            r_shadow_pt     <= '0;
            r_seen          <= '0;
            r_disp_val      <= '0;
            r_point         <= '0;
            r_frame_valid   <= 1'b0;
            r_frame_changed <= 1'b0;
            r_decode_err    <= 1'b0;
        end else begin
            r_digit <= digit;
            if (!w_stable)
                r_settle_cnt <= '0;
            else if (r_settle_cnt != c_SET_W'(SETTLE))
                r_settle_cnt <= r_settle_cnt + c_SET_W'(1);

            r_decode_err    <= w_sample && !w_dec.hit;
            r_frame_valid   <= 1'b0;
            r_frame_changed <= 1'b0;

            if (w_accept) begin
                r_shadow_val[{w_index, 2'b00} +: 4] <= w_dec.nibble;
                r_shadow_pt[w_index]                <= ~segment[0];
            end

            // A full seen mask publishes the shadow and starts a new frame.
            if (r_seen == '1) begin
                r_disp_val      <= r_shadow_val;
                r_point         <= r_shadow_pt;
                r_frame_valid   <= 1'b1;
                r_frame_changed <= ({r_shadow_val, r_shadow_pt} != {r_disp_val, r_point});
                r_seen          <= w_accept ? (NUM_DIGITS'(1) << w_index) : '0;
            end else if (w_accept) begin
                r_seen[w_index] <= 1'b1;
            end

            if (w_accept)
                r_timeout_cnt <= '0;
            else if (r_timeout_cnt != c_TO_W'(TIMEOUT))
                r_timeout_cnt <= r_timeout_cnt + c_TO_W'(1);
        end
    end

    assign dispValOut   = r_disp_val;
    assign pointOut     = r_point;
    assign frameValid   = r_frame_valid;
    assign frameChanged = r_frame_changed;
    assign decodeErr    = r_decode_err;
    assign scanLost     = (r_timeout_cnt == c_TO_W'(TIMEOUT));

endmodule
`default_nettype wire
